mode_select: RTL and testbench
==============================

# mode_select

Generates the 5-bit one-hot `SEL_MODE` bus from the two raw front-panel push buttons of the 24-hour clock. It feeds the LED color decoder, the display multiplexer and the per-mode counters. The block synchronizes and debounces both buttons, then steps a mode state machine:

- a short press of MODE cycles the run modes;
- a long hold of SET in TIME mode enters SET_TIME.

## Interface
Parameters:
- `DEB_CNT`, 20: consecutive `EN_1KHZ` ticks a raw level must hold before the debounced level follows (20 ms).
- `HOLD_CNT`, 2000: `EN_1KHZ` ticks BTN_SET must stay debounced-high to count as a long hold (2 s).

Ports (clock and reset first):
- `CLK`, input, 1: system clock, single domain.
- `RST`, input, 1: reset, asynchronous, active-high.
- `EN_1KHZ`, input, 1: one-`CLK`-wide enable pulse at 1 kHz from the existing prescaler.
- `BTN_MODE`, input, 1: raw MODE button, active-high, asynchronous to `CLK`.
- `BTN_SET`, input, 1: raw SET button, active-high, asynchronous to `CLK`.
- `SEL_MODE`, output, 5: current mode, registered, one of the `param.v` encodings.
- `MODE_CHG`, output, 1: single-cycle pulse, high in the first cycle in which `SEL_MODE` shows a new value.

## Operation
Mode encodings, shared with all consumers:
- `TIME` = 5'b00001
- `SET_TIME` = 5'b00010
- `ALARM` = 5'b00100
- `KITCHEN` = 5'b01000
- `STOPWATCH` = 5'b10000

Button front end, per button:
- 2-FF synchronizer.
- Debounce counter that advances only on `EN_1KHZ` while the synchronized level differs from the debounced level. The counter clears whenever the two levels agree.
- When the counter reaches `DEB_CNT`, the debounced level toggles.
- Press event = debounced 0→1 edge, one `CLK` wide. Release generates no event.

Mode state machine (state register is `SEL_MODE`):
- MODE press: TIME→ALARM→KITCHEN→STOPWATCH→TIME.
- MODE press in SET_TIME: returns to TIME.
- SET long hold, evaluated only in TIME:
  - The hold counter advances on `EN_1KHZ` while debounced SET is high.
  - It clears on debounced SET low.
  - On reaching `HOLD_CNT`, the block goes to SET_TIME, and the counter saturates and stays disarmed until SET is released.
  - One transition per hold.
- SET outside TIME: no effect on the mode (the downstream counters consume SET themselves). The hold counter is held clear.
- Simultaneous MODE press and hold-threshold in the same cycle: MODE wins, so TIME→ALARM, and the hold is disarmed until SET is released.
- Illegal `SEL_MODE` value (not exactly one of the five encodings): next cycle forced to TIME with `MODE_CHG`=1.

## Timing
- Reset values:
  - `SEL_MODE` = TIME, `MODE_CHG` = 0.
  - Synchronizers, debounced levels and all counters = 0.
  - Hold counter armed.
- Reset mid-debounce or mid-hold discards all progress. A button still held after reset release must first debounce high (`DEB_CNT` ticks) before it produces a press, so a held MODE produces exactly one press after reset.
- Latency from raw edge to `SEL_MODE`:
  - 2 cycles of synchronizer.
  - `DEB_CNT` ticks of debounce.
  - 1 cycle to register the new mode.
  - `MODE_CHG` is asserted in that same cycle.
- Bounces shorter than `DEB_CNT` ticks produce no event, and the debounce counter restarts.
- `SEL_MODE` changes at most once per `CLK` and only on a press or hold event.

## Structure
- Mode encodings (`TIME`, `SET_TIME`, `ALARM`, `KITCHEN`, `STOPWATCH`) stay in the shared `param.v`, included by this block and all consumers. No local copies.
- `DEB_CNT` and `HOLD_CNT` are module parameters, not shared constants.
- One sub-module, `btn_debounce`, contains the synchronizer, debounce counter, debounced level and press pulse. It is instantiated twice.
- Target size: ~200 lines in total.

## Test plan
Benches run with `DEB_CNT`=3 and `HOLD_CNT`=10 for speed.
- Reset, then four clean MODE presses → `SEL_MODE` goes 00100, 01000, 10000, 00001, with one `MODE_CHG` pulse per step.
- MODE bouncing (1 for 2 ticks, 0 for 1, then stable 1) → exactly one transition, `DEB_CNT` ticks after the last edge.
- In TIME, hold SET for 15 ticks → SET_TIME (00010) after tick 10, then no further change. A MODE press then returns to 00001.
- In ALARM, hold SET for 20 ticks → `SEL_MODE` stays 00100 and `MODE_CHG` never pulses.
- In TIME, MODE press lands in the same cycle SET reaches `HOLD_CNT` → ALARM. Continued SET hold gives no SET_TIME until SET is released and re-held.
- Assert `RST` while in KITCHEN with MODE held → `SEL_MODE`=00001 and `MODE_CHG`=0 immediately. After release, exactly one press occurs, giving 00100 after `DEB_CNT` ticks.

Source files
------------

// File: rtl/mode_select_pkg.sv
// Mode encodings shared by mode_select and every SEL_MODE consumer
// (LED colour decoder, display multiplexer, per-mode counters).
package mode_select_pkg;

  typedef enum logic [4:0] {
    TIME      = 5'b00001,
    SET_TIME  = 5'b00010,
    ALARM     = 5'b00100,
    KITCHEN   = 5'b01000,
    STOPWATCH = 5'b10000
  } mode_e;

  // A legal mode has exactly one bit set.
  function automatic logic is_legal_mode(input logic [4:0] m);
    return $onehot(m);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchronizer, tick-based debounce counter,
// debounced level and a one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEB_CNT = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // The level flips on the tick that would take the counter to DEB_CNT.
  assign w_flip = i_tick && (r_sync2 != r_level) && (r_cnt == DEB_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Any agreement between raw and debounced levels restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (w_flip) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else if (i_tick) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_level = r_level;
  assign o_press = w_flip && !r_level;

endmodule

// File: rtl/mode_select.sv
// Front-panel mode selector: debounces MODE and SET, cycles run modes on a
// MODE press and enters SET_TIME on a long SET hold while in TIME.
module mode_select
  import mode_select_pkg::*;
#(
  parameter int DEB_CNT  = 20,
  parameter int HOLD_CNT = 2000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN_1KHZ,
  input  logic       BTN_MODE,
  input  logic       BTN_SET,
  output logic [4:0] SEL_MODE,
  output logic       MODE_CHG
);

  localparam int HW = $clog2(HOLD_CNT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CNT);

  mode_e         r_mode;
  mode_e         w_next;
  logic          r_mode_chg;
  logic [HW-1:0] r_hold_cnt;
  logic          r_hold_armed;
  logic          w_mode_press;
  logic          w_mode_level;
  logic          w_set_press;
  logic          w_set_level;
  logic          w_hold_hit;
  logic          w_unused_ok;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_btn_mode (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_tick  (EN_1KHZ),
    .i_btn   (BTN_MODE),
    .o_level (w_mode_level),
    .o_press (w_mode_press)
  );

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_btn_set (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_tick  (EN_1KHZ),
    .i_btn   (BTN_SET),
    .o_level (w_set_level),
    .o_press (w_set_press)
  );

  // MODE only matters as a press and SET only as a level.
  assign w_unused_ok = w_mode_level ^ w_set_press;

  assign w_hold_hit = (r_mode == TIME) && w_set_level && r_hold_armed &&
                      EN_1KHZ && (r_hold_cnt == HOLD_LAST);

  // A hit disarms until SET is released, even when MODE wins that cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold_cnt   <= '0;
      r_hold_armed <= 1'b1;
    end else if (!w_set_level) begin
      r_hold_cnt   <= '0;
      r_hold_armed <= 1'b1;
    end else if (r_mode != TIME) begin
      r_hold_cnt <= '0;
    end else if (w_hold_hit) begin
      r_hold_cnt   <= HOLD_SAT;
      r_hold_armed <= 1'b0;
    end else if (EN_1KHZ && r_hold_armed) begin
      r_hold_cnt <= r_hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode     <= TIME;
      r_mode_chg <= 1'b0;
    end else begin
      r_mode     <= w_next;
      r_mode_chg <= (w_next != r_mode);
    end
  end

  always_comb begin
    w_next = r_mode;
    if (!is_legal_mode(r_mode)) begin
      w_next = TIME;
    end else begin
      case (r_mode)
        TIME: begin
          if (w_mode_press)    w_next = ALARM;
          else if (w_hold_hit) w_next = SET_TIME;
        end
        SET_TIME:  if (w_mode_press) w_next = TIME;
        ALARM:     if (w_mode_press) w_next = KITCHEN;
        KITCHEN:   if (w_mode_press) w_next = STOPWATCH;
        STOPWATCH: if (w_mode_press) w_next = TIME;
        default:   w_next = TIME;
      endcase
    end
  end

  assign SEL_MODE = r_mode;
  assign MODE_CHG = r_mode_chg;

endmodule

// File: tb/tb_mode_select.sv
// Directed bench for mode_select with short debounce/hold constants;
// EN_1KHZ is a one-cycle pulse every four clocks.
module tb_mode_select;

  localparam int DEB  = 3;
  localparam int HOLD = 10;

  localparam logic [4:0] M_TIME    = 5'b00001;
  localparam logic [4:0] M_SET     = 5'b00010;
  localparam logic [4:0] M_ALARM   = 5'b00100;
  localparam logic [4:0] M_KITCHEN = 5'b01000;
  localparam logic [4:0] M_STOP    = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       btnMode;
  logic       btnSet;
  logic [4:0] selMode;
  logic       modeChg;

  int total    = 0;
  int bad      = 0;
  int chgCount = 0;
  int chgBase  = 0;

  mode_select #(.DEB_CNT(DEB), .HOLD_CNT(HOLD)) dut (
    .CLK      (clk),
    .RST      (rst),
    .EN_1KHZ  (en),
    .BTN_MODE (btnMode),
    .BTN_SET  (btnSet),
    .SEL_MODE (selMode),
    .MODE_CHG (modeChg)
  );

  always #5 clk = ~clk;

  // Tally MODE_CHG pulses just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (modeChg === 1'b1) chgCount++;
  end

  task automatic tick();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic stepMode();
    btnMode = 1'b1;
    settle();
    ticks(DEB);
    btnMode = 1'b0;
    settle();
    ticks(DEB);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; btnMode = 1'b0; btnSet = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (selMode !== M_TIME) begin
      bad++; $display("[TB] FAIL reset_sel: got %b want %b", selMode, M_TIME);
    end
    total++;
    if (modeChg !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_chg: got %b want 0", modeChg);
    end
    @(negedge clk) rst = 1'b0;
    settle();
  endtask

  task automatic test_mode_cycle();
    logic [4:0] seq [4];
    seq = '{M_ALARM, M_KITCHEN, M_STOP, M_TIME};
    for (int i = 0; i < 4; i++) begin
      chgBase = chgCount;
      btnMode = 1'b1;
      settle();
      ticks(DEB);
      total++;
      if (selMode !== seq[i]) begin
        bad++; $display("[TB] FAIL cycle_press[%0d]: got %b want %b", i, selMode, seq[i]);
      end
      btnMode = 1'b0;
      settle();
      ticks(DEB);
      total++;
      if (selMode !== seq[i]) begin
        bad++; $display("[TB] FAIL cycle_release[%0d]: got %b want %b", i, selMode, seq[i]);
      end
      total++;
      if (chgCount - chgBase !== 1) begin
        bad++; $display("[TB] FAIL cycle_chg[%0d]: pulses %0d want 1", i, chgCount - chgBase);
      end
    end
  endtask

  task automatic test_bounce();
    chgBase = chgCount;
    btnMode = 1'b1; settle(); ticks(2);
    btnMode = 1'b0; settle(); ticks(1);
    btnMode = 1'b1; settle(); ticks(DEB - 1);
    total++;
    if (selMode !== M_TIME || chgCount != chgBase) begin
      bad++; $display("[TB] FAIL bounce_early: got %b pulses %0d want %b pulses 0",
                      selMode, chgCount - chgBase, M_TIME);
    end
    ticks(1);
    total++;
    if (selMode !== M_ALARM || chgCount - chgBase != 1) begin
      bad++; $display("[TB] FAIL bounce_event: got %b pulses %0d want %b pulses 1",
                      selMode, chgCount - chgBase, M_ALARM);
    end
    btnMode = 1'b0; settle(); ticks(DEB);
    repeat (3) stepMode();
    total++;
    if (selMode !== M_TIME) begin
      bad++; $display("[TB] FAIL bounce_back: got %b want %b", selMode, M_TIME);
    end
  endtask

  task automatic test_set_hold();
    chgBase = chgCount;
    btnSet = 1'b1; settle();
    ticks(DEB + HOLD - 1);
    total++;
    if (selMode !== M_TIME) begin
      bad++; $display("[TB] FAIL hold_early: got %b want %b", selMode, M_TIME);
    end
    ticks(1);
    total++;
    if (selMode !== M_SET || chgCount - chgBase != 1) begin
      bad++; $display("[TB] FAIL hold_enter: got %b pulses %0d want %b pulses 1",
                      selMode, chgCount - chgBase, M_SET);
    end
    ticks(5);
    total++;
    if (selMode !== M_SET || chgCount - chgBase != 1) begin
      bad++; $display("[TB] FAIL hold_stay: got %b pulses %0d want %b pulses 1",
                      selMode, chgCount - chgBase, M_SET);
    end
    stepMode();
    total++;
    if (selMode !== M_TIME) begin
      bad++; $display("[TB] FAIL hold_exit: got %b want %b", selMode, M_TIME);
    end
    ticks(HOLD + 2);
    total++;
    if (selMode !== M_TIME || chgCount - chgBase != 2) begin
      bad++; $display("[TB] FAIL hold_disarmed: got %b pulses %0d want %b pulses 2",
                      selMode, chgCount - chgBase, M_TIME);
    end
    btnSet = 1'b0; settle(); ticks(DEB);
  endtask

  task automatic test_set_in_alarm();
    stepMode();
    chgBase = chgCount;
    btnSet = 1'b1; settle(); ticks(20);
    total++;
    if (selMode !== M_ALARM || chgCount != chgBase) begin
      bad++; $display("[TB] FAIL alarm_set: got %b pulses %0d want %b pulses 0",
                      selMode, chgCount - chgBase, M_ALARM);
    end
    btnSet = 1'b0; settle(); ticks(DEB);
    total++;
    if (selMode !== M_ALARM || chgCount != chgBase) begin
      bad++; $display("[TB] FAIL alarm_release: got %b pulses %0d want %b pulses 0",
                      selMode, chgCount - chgBase, M_ALARM);
    end
    repeat (3) stepMode();
  endtask

  task automatic test_simultaneous();
    chgBase = chgCount;
    btnSet = 1'b1; settle();
    ticks(DEB + HOLD - DEB);
    btnMode = 1'b1; settle();
    ticks(DEB - 1);
    total++;
    if (selMode !== M_TIME || chgCount != chgBase) begin
      bad++; $display("[TB] FAIL simul_pre: got %b pulses %0d want %b pulses 0",
                      selMode, chgCount - chgBase, M_TIME);
    end
    ticks(1);
    total++;
    if (selMode !== M_ALARM || chgCount - chgBase != 1) begin
      bad++; $display("[TB] FAIL simul_hit: got %b pulses %0d want %b pulses 1",
                      selMode, chgCount - chgBase, M_ALARM);
    end
    btnMode = 1'b0; settle(); ticks(DEB);
    repeat (3) stepMode();
    ticks(HOLD + 2);
    total++;
    if (selMode !== M_TIME) begin
      bad++; $display("[TB] FAIL simul_disarmed: got %b want %b", selMode, M_TIME);
    end
    btnSet = 1'b0; settle(); ticks(DEB);
    btnSet = 1'b1; settle(); ticks(DEB + HOLD);
    total++;
    if (selMode !== M_SET) begin
      bad++; $display("[TB] FAIL simul_rehold: got %b want %b", selMode, M_SET);
    end
    btnSet = 1'b0; settle(); ticks(DEB);
    stepMode();
    total++;
    if (selMode !== M_TIME) begin
      bad++; $display("[TB] FAIL simul_back: got %b want %b", selMode, M_TIME);
    end
  endtask

  task automatic test_reset_held();
    stepMode();
    btnMode = 1'b1; settle();
    ticks(DEB - 1);
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    total++;
    if (selMode !== M_KITCHEN || modeChg !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_pre: got %b chg %b want %b chg 1", selMode, modeChg, M_KITCHEN);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (selMode !== M_TIME || modeChg !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_async: got %b chg %b want %b chg 0", selMode, modeChg, M_TIME);
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    chgBase = chgCount;
    settle();
    ticks(DEB - 1);
    total++;
    if (selMode !== M_TIME || chgCount != chgBase) begin
      bad++; $display("[TB] FAIL rst_early: got %b pulses %0d want %b pulses 0",
                      selMode, chgCount - chgBase, M_TIME);
    end
    ticks(1);
    total++;
    if (selMode !== M_ALARM || chgCount - chgBase != 1) begin
      bad++; $display("[TB] FAIL rst_press: got %b pulses %0d want %b pulses 1",
                      selMode, chgCount - chgBase, M_ALARM);
    end
    ticks(5);
    btnMode = 1'b0; settle(); ticks(DEB);
    total++;
    if (selMode !== M_ALARM || chgCount - chgBase != 1) begin
      bad++; $display("[TB] FAIL rst_single: got %b pulses %0d want %b pulses 1",
                      selMode, chgCount - chgBase, M_ALARM);
    end
  endtask

  initial begin
    $display("[TB] starting mode_select bench");
    test_reset();
    test_mode_cycle();
    test_bounce();
    test_set_hold();
    test_set_in_alarm();
    test_simultaneous();
    test_reset_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
